pfd_tdc: RTL and testbench
==========================

PFD_TDC -- requirements
Module: pfd_tdc

Interface
REQ-001 Parameter WIDTH, default 8: phase-count magnitude width in clk cycles.
REQ-002 Parameter SYNC_STAGES, default 2, minimum 2: synchroniser flops per input.
REQ-003 Parameter LOCK_TOL, default 2: largest |err| counted as in-lock.
REQ-004 Parameter LOCK_CNT, default 16, minimum 1: consecutive in-lock measurements needed to assert lock.
REQ-005 clk  in  1  sampling clock; all state changes on its rising edge.
REQ-006 rst  in  1  reset; asynchronous, active-high.
REQ-007 en  in  1  measurement enable.
REQ-008 f_ref  in  1  reference clock; asynchronous to clk.
REQ-009 f_div  in  1  divided VCO clock; asynchronous to clk.
REQ-010 up  out  1  high while a ref-leading measurement is open.
REQ-011 dn  out  1  high while a div-leading measurement is open.
REQ-012 dir  out  1  last lead direction: 1 = ref led, 0 = div led.
REQ-013 err  out  WIDTH+1  signed two's-complement phase error in clk cycles; positive = ref leads.
REQ-014 err_valid  out  1  one-cycle strobe: err updated.
REQ-015 lock  out  1  lock indication.
REQ-016 slip  out  1  one-cycle strobe: cycle slip detected.

Function
REQ-017 Each input passes through SYNC_STAGES flops, then a rising-edge detector (synced value high, previous synced value low), giving ref_rise / div_rise events.
REQ-018 FSM states: IDLE, REF_LEAD, DIV_LEAD; all outputs registered.
REQ-019 IDLE, ref_rise only -> REF_LEAD, cnt=1. div_rise only -> DIV_LEAD, cnt=1. Both -> stay IDLE, err=0, err_valid=1.
REQ-020 REF_LEAD, no div_rise: cnt increments by 1 per cycle, saturating at 2^WIDTH-1.
REQ-021 REF_LEAD, div_rise: err=+cnt, err_valid=1. With no ref_rise in that cycle -> IDLE. With ref_rise in that cycle -> stay REF_LEAD, cnt=1 (new measurement).
REQ-022 REF_LEAD, ref_rise without div_rise: slip=1 for one cycle; cnt continues from the first edge; state unchanged.
REQ-023 DIV_LEAD mirrors REQ-020..022 with roles swapped; err=-cnt.
REQ-024 up=1 exactly in REF_LEAD and dn=1 exactly in DIV_LEAD; up and dn are never both 1.
REQ-025 A measurement whose edges are N cycles apart gives up (or dn) high for N cycles, err=±min(N, 2^WIDTH-1).
REQ-026 err, err_valid, lock and slip update on the clk edge that closes the event cycle.
REQ-027 dir: set to 1 when REF_LEAD is entered, cleared to 0 when DIV_LEAD is entered, held otherwise, including in IDLE and on a zero err.
REQ-028 Lock counter lcnt (saturates at LOCK_CNT), updated on each err_valid:
- |err| <= LOCK_TOL: lcnt increments.
- Otherwise: lcnt = 0.
REQ-029 slip clears lcnt.
REQ-030 lock = (lcnt == LOCK_CNT), updated in the same cycle as err_valid or slip.
REQ-031 err holds its value between strobes.
REQ-032 en=0: next state IDLE; cnt=0, up=dn=0, lcnt=0, lock=0; no err_valid or slip. err and dir hold. Synchronisers and edge history keep running, so re-enabling on a high input creates no false edge.

Reset
REQ-033 rst=1 immediately forces: FSM IDLE, cnt=0, lcnt=0, synchronisers and edge history 0, and up=dn=dir=err_valid=lock=slip=0, err=0.
REQ-034 rst asserted mid-measurement discards that measurement; no err_valid is produced for it after release.
REQ-035 After rst deasserts, the first qualifying edge starts a fresh measurement.

Verification
Common setup: WIDTH=8, SYNC_STAGES=2, LOCK_TOL=2, LOCK_CNT=4, en=1, both inputs with period 20 clk.
REQ-036 div lags ref by 5 clk -> up high 5 cycles, dn 0, err=+5 (0x005), err_valid one pulse, dir=1.
REQ-037 ref lags div by 3 clk -> dn high 3 cycles, err=-3 (0x1FD), dir=0.
REQ-038 aligned inputs -> err_valid each period with err=0, up=dn=0, lock=1 at the 4th strobe.
REQ-039 locked, then one period with div lag 7 -> err=+7, lock=0 in the same cycle as err_valid; 4 aligned periods later lock=1.
REQ-040 f_div held low for 600 clk while f_ref runs -> slip pulses on each ref edge after the first, cnt saturates; first div edge gives err=+255.
REQ-041 rst pulsed during REF_LEAD -> up, lock and err cleared asynchronously; no err_valid until a new measurement completes.

Source files
------------

// File: rtl/pfd_tdc_if.sv
// Phase/frequency detector bus: async clock inputs and enable in, measurement
// results and strobes out.
interface pfd_tdc_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             f_ref;
  logic             f_div;
  logic             up;
  logic             dn;
  logic             dir;
  logic [WIDTH:0]   err;
  logic             err_valid;
  logic             lock;
  logic             slip;

  modport master (
    output en, f_ref, f_div,
    input  up, dn, dir, err, err_valid, lock, slip
  );

  modport slave (
    input  en, f_ref, f_div,
    output up, dn, dir, err, err_valid, lock, slip
  );
endinterface

// File: rtl/pfd_tdc.sv
// Digital PFD + time-to-digital converter: measures the clk-cycle distance
// between synchronised f_ref and f_div rising edges and tracks lock.
module pfd_tdc #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_TOL    = 2,
  parameter int LOCK_CNT    = 16
) (
  input  logic       clk,
  input  logic       rst,
  pfd_tdc_if.slave   bus
);
  localparam int             LW       = $clog2(LOCK_CNT + 1);
  localparam logic [WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [LW-1:0]  LCNT_MAX = LW'(LOCK_CNT);
  localparam logic [31:0]    TOL      = LOCK_TOL;

  typedef enum logic [1:0] {IDLE, REF_LEAD, DIV_LEAD} state_t;

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] ref_sync, div_sync;
  logic                   ref_prev, div_prev;
  logic                   ref_rise, div_rise;
  logic [WIDTH-1:0]       cnt, cnt_n, mag;
  logic [LW-1:0]          lcnt, lcnt_n;
  logic [WIDTH:0]         err_n;
  logic                   ev_n, slip_n, dir_n;

  // Synchronisers and edge history run regardless of en, so re-enabling
  // while an input is already high does not fabricate an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_sync <= '0;
      div_sync <= '0;
      ref_prev <= 1'b0;
      div_prev <= 1'b0;
    end else begin
      ref_sync <= {ref_sync[SYNC_STAGES-2:0], bus.f_ref};
      div_sync <= {div_sync[SYNC_STAGES-2:0], bus.f_div};
      ref_prev <= ref_sync[SYNC_STAGES-1];
      div_prev <= div_sync[SYNC_STAGES-1];
    end
  end

  assign ref_rise = ref_sync[SYNC_STAGES-1] & ~ref_prev;
  assign div_rise = div_sync[SYNC_STAGES-1] & ~div_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (!bus.en) state_n = IDLE;
    else begin
      case (state)
        IDLE:     if (ref_rise && !div_rise)      state_n = REF_LEAD;
                  else if (div_rise && !ref_rise) state_n = DIV_LEAD;
        REF_LEAD: if (div_rise && !ref_rise)      state_n = IDLE;
        DIV_LEAD: if (ref_rise && !div_rise)      state_n = IDLE;
        default:  state_n = IDLE;
      endcase
    end
  end

  // A lagging edge closes the measurement; a second leading edge on the
  // same side in the same cycle immediately opens the next one.
  always_comb begin
    cnt_n  = (cnt == CNT_MAX) ? cnt : cnt + WIDTH'(1);
    err_n  = bus.err;
    ev_n   = 1'b0;
    slip_n = 1'b0;
    dir_n  = bus.dir;
    mag    = '0;
    lcnt_n = lcnt;
    if (!bus.en) begin
      cnt_n  = '0;
      lcnt_n = '0;
    end else begin
      case (state)
        IDLE: begin
          cnt_n = '0;
          if (ref_rise && div_rise) begin
            err_n = '0;
            ev_n  = 1'b1;
          end else if (ref_rise) begin
            cnt_n = WIDTH'(1);
            dir_n = 1'b1;
          end else if (div_rise) begin
            cnt_n = WIDTH'(1);
            dir_n = 1'b0;
          end
        end
        REF_LEAD: begin
          if (div_rise) begin
            err_n = {1'b0, cnt};
            ev_n  = 1'b1;
            mag   = cnt;
            cnt_n = ref_rise ? WIDTH'(1) : '0;
          end else begin
            slip_n = ref_rise;
          end
        end
        DIV_LEAD: begin
          if (ref_rise) begin
            err_n = '0 - {1'b0, cnt};
            ev_n  = 1'b1;
            mag   = cnt;
            cnt_n = div_rise ? WIDTH'(1) : '0;
          end else begin
            slip_n = div_rise;
          end
        end
        default: cnt_n = '0;
      endcase
      if (slip_n) lcnt_n = '0;
      else if (ev_n) begin
        if (32'(mag) <= TOL) lcnt_n = (lcnt == LCNT_MAX) ? lcnt : lcnt + LW'(1);
        else                 lcnt_n = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt           <= '0;
      lcnt          <= '0;
      bus.up        <= 1'b0;
      bus.dn        <= 1'b0;
      bus.dir       <= 1'b0;
      bus.err       <= '0;
      bus.err_valid <= 1'b0;
      bus.lock      <= 1'b0;
      bus.slip      <= 1'b0;
    end else begin
      cnt           <= cnt_n;
      lcnt          <= lcnt_n;
      bus.up        <= (state_n == REF_LEAD);
      bus.dn        <= (state_n == DIV_LEAD);
      bus.dir       <= dir_n;
      bus.err       <= err_n;
      bus.err_valid <= ev_n;
      bus.lock      <= (lcnt_n == LCNT_MAX);
      bus.slip      <= slip_n;
    end
  end
endmodule

// File: tb/tb_pfd_tdc.sv
// Scoreboard bench for pfd_tdc: a timestamp-based edge model predicts every
// err/slip strobe; a monitor pops and compares when the DUT strobes.
module tb_pfd_tdc;
  localparam int W   = 8;
  localparam int SAT = 255;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pfd_tdc_if #(.WIDTH(W)) u ();

  pfd_tdc #(.WIDTH(W), .SYNC_STAGES(2), .LOCK_TOL(2), .LOCK_CNT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u)
  );

  typedef struct {
    bit is_slip;
    int e;
    bit lk;
    bit dr;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // reference model: edge timestamps, open side (+1 ref, -1 div, 0 none)
  bit pr, pd, mdir;
  int open_side, t0, k, good;

  int   up_len, dn_len, e_act;
  exp_t x;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_err(input int e);
    int a;
    a = (e < 0) ? -e : e;
    if (a <= 2) good = (good < 4) ? good + 1 : 4;
    else        good = 0;
    sb.push_back('{1'b0, e, good == 4, mdir});
  endtask

  task automatic push_slip();
    good = 0;
    sb.push_back('{1'b1, 0, 1'b0, mdir});
  endtask

  task automatic model(input bit r, input bit d);
    bit rr, dd;
    int dt;
    rr = r & !pr;
    dd = d & !pd;
    pr = r;
    pd = d;
    k++;
    dt = (k - t0 > SAT) ? SAT : k - t0;
    if (!u.en) begin
      open_side = 0;
      good      = 0;
    end else if (open_side == 0) begin
      if (rr && dd) push_err(0);
      else if (rr) begin open_side = 1;  t0 = k; mdir = 1'b1; end
      else if (dd) begin open_side = -1; t0 = k; mdir = 1'b0; end
    end else if (open_side == 1) begin
      if (dd) begin
        push_err(dt);
        if (rr) t0 = k; else open_side = 0;
      end else if (rr) push_slip();
    end else begin
      if (rr) begin
        push_err(-dt);
        if (dd) t0 = k; else open_side = 0;
      end else if (dd) push_slip();
    end
  endtask

  task automatic model_reset();
    pr = 1'b0; pd = 1'b0; open_side = 0; good = 0; mdir = 1'b0;
  endtask

  task automatic step(input bit r, input bit d);
    @(negedge clk);
    u.f_ref = r;
    u.f_div = d;
    model(r, d);
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  // 20-cycle period, 50% duty; positive lag delays f_div behind f_ref
  task automatic period(input int lag, input bit div_off);
    for (int c = 0; c < 20; c++)
      step(c < 10, !div_off && (((c - lag + 20) % 20) < 10));
  endtask

  always @(negedge clk) begin
    if (rst) begin
      up_len = 0;
      dn_len = 0;
    end else begin
      chk("up_dn_exclusive", int'(u.up & u.dn), 0);
      if (u.err_valid || u.slip) begin
        if (sb.size() == 0) chk("unexpected_strobe", 1, 0);
        else begin
          x = sb.pop_front();
          chk("strobe_kind", int'(u.slip), int'(x.is_slip));
          chk("strobe_lock", int'(u.lock), int'(x.lk));
          chk("strobe_dir",  int'(u.dir),  int'(x.dr));
          if (!x.is_slip) chk("err_value", int'($signed(u.err)), x.e);
        end
      end
      if (u.err_valid) begin
        e_act = int'($signed(u.err));
        if (e_act > 0 && e_act < SAT)  chk("up_width", up_len, e_act);
        if (e_act < 0 && e_act > -SAT) chk("dn_width", dn_len, -e_act);
        up_len = 0;
        dn_len = 0;
      end
      if (u.up) up_len++;
      if (u.dn) dn_len++;
      if (!u.en) begin
        up_len = 0;
        dn_len = 0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: got 0 expected 1 (run did not finish)");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    u.en = 1'b1; u.f_ref = 1'b0; u.f_div = 1'b0;
    k = 0; t0 = 0;
    model_reset();
    #2;
    chk("rst_up",   int'(u.up), 0);
    chk("rst_dn",   int'(u.dn), 0);
    chk("rst_dir",  int'(u.dir), 0);
    chk("rst_err",  int'(u.err), 0);
    chk("rst_ev",   int'(u.err_valid), 0);
    chk("rst_lock", int'(u.lock), 0);
    chk("rst_slip", int'(u.slip), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    quiet(4);

    repeat (3) period(5, 1'b0);
    chk("lag5_err", int'(u.err), 5);
    chk("lag5_dir", int'(u.dir), 1);

    repeat (3) period(-3, 1'b0);
    chk("lagm3_err", int'(u.err), 9'h1FD);
    chk("lagm3_dir", int'(u.dir), 0);

    repeat (6) period(0, 1'b0);
    chk("aligned_lock", int'(u.lock), 1);
    chk("aligned_up",   int'(u.up), 0);
    chk("aligned_err",  int'(u.err), 0);

    period(7, 1'b0);
    chk("lag7_err",  int'(u.err), 7);
    chk("lag7_lock", int'(u.lock), 0);
    repeat (4) period(0, 1'b0);
    chk("relock", int'(u.lock), 1);

    // disable while a div-led measurement is open; err and dir must hold
    repeat (2) period(-3, 1'b0);
    quiet(6);
    u.en = 1'b0;
    quiet(3);
    chk("dis_dn",   int'(u.dn), 0);
    chk("dis_lock", int'(u.lock), 0);
    chk("dis_err",  int'(u.err), 9'h1FD);
    chk("dis_dir",  int'(u.dir), 0);
    for (int i = 0; i < 18; i++) begin
      if (i == 12) u.en = 1'b1;
      step(1'b1, 1'b0);
    end
    quiet(6);
    chk("reen_no_edge_up", int'(u.up), 0);
    chk("reen_err_hold",   int'(u.err), 9'h1FD);

    repeat (6) period(0, 1'b0);
    chk("pre_rst_lock", int'(u.lock), 1);
    repeat (3) step(1'b1, 1'b0);
    quiet(3);
    chk("pre_rst_up", int'(u.up), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_up",   int'(u.up), 0);
    chk("async_rst_lock", int'(u.lock), 0);
    chk("async_rst_err",  int'(u.err), 0);
    chk("async_rst_dir",  int'(u.dir), 0);
    model_reset();
    quiet(3);
    rst = 1'b0;
    quiet(6);
    chk("post_rst_ev", int'(u.err_valid), 0);
    repeat (5) period(0, 1'b0);
    chk("post_rst_lock", int'(u.lock), 1);

    // div stalls for 600 cycles: slips on every later ref edge, then saturation
    quiet(4);
    repeat (30) period(0, 1'b1);
    period(5, 1'b0);
    chk("sat_err",  int'(u.err), SAT);
    chk("sat_dir",  int'(u.dir), 1);
    chk("sat_lock", int'(u.lock), 0);

    for (int p = 0; p < 40; p++) period(int'($urandom_range(18)) - 9, 1'b0);
    for (int i = 0; i < 600; i++)
      step(($urandom_range(4) == 0) ? !u.f_ref : u.f_ref,
           ($urandom_range(4) == 0) ? !u.f_div : u.f_div);
    quiet(10);
    chk("sb_drain", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
